// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction ROM port, redirect input and
// the valid/ready instruction stream toward decode.
interface fetch_sequencer_if #(
  parameter int WIDTH = 24
) ();
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rd;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             inst_valid;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_ready;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, reads the ROM and queues
// {pc, word} pairs for decode; handles start, redirect and halt.
module fetch_sequencer #(
  parameter int               WIDTH     = 24,
  parameter int               AMOUNT    = 256,
  parameter int               DEPTH     = 2,
  parameter int               RESET_PC  = 0,
  parameter logic [WIDTH-1:0] HALT_WORD = WIDTH'(24'hFFFFFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  fetch_sequencer_if.master bus
);

  localparam int AW = $clog2(AMOUNT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [WIDTH-1:0] inst_mem_q [DEPTH];
  logic [AW-1:0]    pc_mem_q   [DEPTH];

  logic          push;
  logic          pop;
  logic          flush;
  logic          has_room;
  logic          is_halt;
  logic [AW-1:0] target;

  assign pop      = (count_q != '0) && bus.inst_ready;
  assign has_room = (count_q != FULL) || pop;
  assign is_halt  = (bus.imem_rd == HALT_WORD);
  assign target   = bus.redirect_pc[AW-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.redirect_valid) pc_d = target;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
          pc_d  = target;
        end else if (has_room) begin
          push = 1'b1;
          // halt word is queued but the PC parks on it
          if (is_halt) state_d = S_HALT;
          else         pc_d    = pc_q + AW'(1);
        end
      end
      S_HALT: begin
        if (bus.redirect_valid) begin
          flush   = 1'b1;
          pc_d    = target;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_RST;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= bus.imem_rd;
      pc_mem_q[wr_ptr_q]   <= pc_q;
    end
  end

  assign bus.imem_addr  = {{(WIDTH-AW){1'b0}}, pc_q};
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = inst_mem_q[rd_ptr_q];
  assign bus.inst_pc    = {{(WIDTH-AW){1'b0}}, pc_mem_q[rd_ptr_q]};

  assign busy   = (state_q == S_FETCH);
  assign halted = (state_q == S_HALT) && (count_q == '0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a queue-based model,
// plus a second instance with the PC reset near the top of the ROM.
module tb_fetch_sequencer;

  localparam int          W  = 24;
  localparam int          A  = 256;
  localparam int          D  = 2;
  localparam logic [23:0] HW = 24'hFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, start1, busy1, halted1;
  logic rst2_n, start2, busy2, halted2;

  fetch_sequencer_if #(.WIDTH(W)) b1 ();
  fetch_sequencer_if #(.WIDTH(W)) b2 ();

  logic [23:0] rom [A];

  assign b1.imem_rd = rom[b1.imem_addr[7:0]];
  assign b2.imem_rd = rom[b2.imem_addr[7:0]];

  fetch_sequencer #(
    .WIDTH(W), .AMOUNT(A), .DEPTH(D),
    .RESET_PC(0), .HALT_WORD(HW)
  ) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1),
    .busy(busy1), .halted(halted1), .bus(b1)
  );

  fetch_sequencer #(
    .WIDTH(W), .AMOUNT(A), .DEPTH(D),
    .RESET_PC(254), .HALT_WORD(HW)
  ) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .busy(busy2), .halted(halted2), .bus(b2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // model: mode 0 idle, 1 running, 2 parked on halt word
  logic [47:0] mq[$];
  int mpc;
  int mmode;

  task automatic check_outputs();
    chk("valid", 32'(b1.inst_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("inst", 32'(b1.inst), 32'(mq[0][23:0]));
      chk("inst_pc", 32'(b1.inst_pc), 32'(mq[0][47:24]));
    end
    chk("addr", 32'(b1.imem_addr), 32'(mpc));
    chk("busy", 32'(busy1), 32'(mmode == 1));
    chk("halted", 32'(halted1),
        32'(mmode == 2 && mq.size() == 0));
  endtask

  task automatic model_update(input logic st, input logic rv,
                              input logic [23:0] rpc,
                              input logic rdy, input logic rs);
    logic pop;
    if (!rs) begin
      mpc   = 0;
      mmode = 0;
      mq.delete();
      return;
    end
    pop = (mq.size() > 0) && rdy;
    case (mmode)
      0: begin
        if (rv) mpc = int'(rpc) % A;
        if (st) mmode = 1;
      end
      1: begin
        if (rv) begin
          mq.delete();
          mpc = int'(rpc) % A;
        end else begin
          if (pop) void'(mq.pop_front());
          if (mq.size() < D) begin
            mq.push_back({24'(mpc), rom[mpc]});
            if (rom[mpc] == HW) mmode = 2;
            else mpc = (mpc + 1) % A;
          end
        end
      end
      default: begin
        if (rv) begin
          mq.delete();
          mpc   = int'(rpc) % A;
          mmode = 1;
        end else if (pop) begin
          void'(mq.pop_front());
        end
      end
    endcase
  endtask

  task automatic step(input logic st, input logic rv,
                      input logic [23:0] rpc,
                      input logic rdy, input logic rs);
    check_outputs();
    start1            = st;
    b1.redirect_valid = rv;
    b1.redirect_pc    = rpc;
    b1.inst_ready     = rdy;
    rst1_n            = rs;
    @(posedge clk);
    model_update(st, rv, rpc, rdy, rs);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, rdy, 1'b1);
  endtask

  task automatic fill_rom(input int halt_pct);
    logic [23:0] v;
    for (int i = 0; i < A; i++) begin
      do v = 24'($urandom); while (v == HW);
      rom[i] = v;
      if (int'($urandom_range(99)) < halt_pct) rom[i] = HW;
    end
  endtask

  int got_pc[$];
  int exp_pc[4];
  logic reached;

  initial begin
    rst1_n = 1'b0; start1 = 1'b0;
    b1.redirect_valid = 1'b0; b1.redirect_pc = '0;
    b1.inst_ready = 1'b0;
    rst2_n = 1'b0; start2 = 1'b0;
    b2.redirect_valid = 1'b0; b2.redirect_pc = '0;
    b2.inst_ready = 1'b1;
    fill_rom(0);

    // second instance: wrap from 254
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst2_n = 1'b1;
    chk("d2_addr", 32'(b2.imem_addr), 32'd254);
    chk("d2_valid", 32'(b2.inst_valid), 32'd0);
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    chk("d2_busy", 32'(busy2), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (b2.inst_valid) begin
        got_pc.push_back(int'(b2.inst_pc));
        chk("d2_inst", 32'(b2.inst), 32'(rom[b2.inst_pc[7:0]]));
      end
      @(posedge clk);
      @(negedge clk);
    end
    exp_pc = '{254, 255, 0, 1};
    chk("d2_count", 32'(got_pc.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < got_pc.size())
        chk("d2_pc", 32'(got_pc[i]), 32'(exp_pc[i]));

    // main instance: bring model and DUT to a known reset state
    @(posedge clk);
    model_update(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("rst_inst", 32'(b1.inst), 32'd0);
    chk("rst_inst_pc", 32'(b1.inst_pc), 32'd0);

    // straight-line fetch with decode always ready
    step(1'b1, 1'b0, 24'h0, 1'b1, 1'b1);
    idle(8, 1'b1);

    // backpressure fills the FIFO, then drains
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
    idle(5, 1'b0);
    idle(8, 1'b1);

    // redirect while fetching pc 5, with a pop in the same cycle
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b1, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (mpc == 5) reached = 1'b1;
      else idle(1, 1'b1);
    end
    chk("reach_pc5", 32'(reached), 32'd1);
    step(1'b0, 1'b1, 24'h000040, 1'b1, 1'b1);
    idle(6, 1'b1);

    // halt word at pc 3, ignored start, redirect restart
    rom[3] = HW;
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b1, 1'b1);
    idle(10, 1'b1);
    step(1'b1, 1'b0, 24'h0, 1'b1, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 24'h0, 1'b1, 1'b1);
    idle(8, 1'b1);
    fill_rom(0);

    // reset while full, then restart
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
    idle(6, 1'b0);
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 24'h0, 1'b1, 1'b1);
    idle(5, 1'b1);

    // random traffic with sparse halt words
    fill_rom(2);
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(9) == 0),
           1'($urandom_range(99) < 8),
           24'($urandom),
           1'($urandom_range(99) < 60),
           1'($urandom_range(99) != 0));
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the processor's instruction ROM: 24-bit words, AMOUNT entries, combinational read.
- Owns the program counter and drives the ROM address every cycle.
- Captures returned words with their PC into a small FIFO and presents them to decode over a valid/ready handshake.
- Handles start, branch redirect with flush, address wrap-around and halt detection.

Parameters:
WIDTH, 24, instruction word width and ROM address port width
AMOUNT, 256, ROM depth in words; power of two; PC range 0..AMOUNT-1
DEPTH, 2, fetch FIFO entries (power of two, >=2)
RESET_PC, 0, PC value loaded at reset
HALT_WORD, 24'hFFFFFF, instruction encoding that stops fetching

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse, begins fetching from IDLE
imem_addr  output  WIDTH  ROM address = PC zero-extended
imem_rd  input  WIDTH  ROM read data, combinational from imem_addr
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  WIDTH  target; low log2(AMOUNT) bits used
inst_valid  output  1  FIFO head holds a valid instruction
inst  output  WIDTH  FIFO head instruction
inst_pc  output  WIDTH  PC of FIFO head, zero-extended
inst_ready  input  1  decode accepts head this cycle
busy  output  1  state is FETCH
halted  output  1  state is HALT and FIFO empty

Behaviour:
- Reset (rst_n=0 at edge): PC=RESET_PC, state IDLE, FIFO empty/pointers 0, inst_valid=0, inst=0, inst_pc=0, busy=0, halted=0. Reset mid-operation discards all FIFO contents and any pending redirect.
- imem_addr = PC at all times, including IDLE and HALT.
- States:
  - IDLE:
    - start=1 -> FETCH; no push in the start cycle.
    - redirect_valid in IDLE loads PC, stays IDLE.
  - FETCH: push condition = no redirect AND (count<DEPTH OR pop this cycle). On push:
    - FIFO gets {PC, imem_rd}.
    - PC <= (PC+1) mod AMOUNT; PC AMOUNT-1 wraps to 0.
    - If imem_rd==HALT_WORD, the halt word is still pushed, PC does not advance, state -> HALT.
  - HALT: no pushes; PC frozen; start ignored. redirect_valid -> flush, PC<=redirect_pc, state FETCH.
- Pop: inst_valid & inst_ready at an edge removes the head.
- Outputs: inst, inst_pc and inst_valid come straight from the FIFO head/count registers, not combinationally from imem_rd.
- Latency: word fetched at edge-cycle t is visible on inst at t+1.
- Back-to-back throughput is 1 instr/cycle when inst_ready is held high.
- Redirect (FETCH or HALT):
  - FIFO flushed (count 0) at that edge.
  - PC <= redirect_pc mod AMOUNT; no push that cycle.
  - A simultaneous pop is discarded and the flush wins.
  - The first target word is pushed the following cycle, so inst_valid=1 two edges after the redirect edge.
- Full: count==DEPTH with no pop -> no push, PC holds.
  - Full with pop in the same cycle -> push and pop both occur; count unchanged.
- Empty: inst_valid=0; inst/inst_pc hold the last values (don't-care for checking).
- halted asserts only after the HALT_WORD entry has been popped.
- busy=1 exactly when state==FETCH.

Test Plan:
1. Reset, start pulse, ROM[0..3]=A,B,C,D, inst_ready=1 -> inst_valid rises 2 edges after start; inst A,B,C,D with inst_pc 0,1,2,3 on consecutive cycles.
2. inst_ready=0 for 5 cycles after start -> FIFO fills to DEPTH=2 holding pc 0,1; PC frozen at 2 (imem_addr=2). Raise ready -> sequence 0,1,2,... with none lost or duplicated.
3. While fetching pc 5, assert redirect_valid with redirect_pc=0x40 and inst_ready=1 in the same cycle -> FIFO flushed, next inst_pc observed = 0x40, no pc 5/6 delivered after the redirect.
4. RESET_PC=AMOUNT-2=254, start, ready=1 -> inst_pc sequence 254, 255, 0, 1.
5. ROM[3]=HALT_WORD -> pcs 0,1,2,3 delivered, busy drops after the pc3 push, halted=1 after pc3 is popped, imem_addr stays 3. A later start has no effect; redirect to 0 restarts fetch from 0.
6. Assert rst_n=0 for one edge while FIFO is full mid-run -> next cycle inst_valid=0, busy=0, imem_addr=RESET_PC; fetch resumes only after a new start.
